// File: rtl/sram_1rw1r_arbiter.sv
// sram_1rw1r_arbiter: schedules two requesters onto a 1rw1r byte-masked SRAM.
// Writes always use rw0 and reads use r0, so one write and one read can finish
// in the same cycle. Out-of-range requests are acknowledged with err and never
// touch the macro.
// Optional build macro SRAM_ARB_STATS_EN adds saturating event counters.
module sram_1rw1r_arbiter #(
  parameter int BITS       = 32,
  parameter int WORD_DEPTH = 384,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [BITS-1:0]       m0_wdata,
  input  logic [3:0]            m0_wmask,
  output logic                  m0_rsp_valid,
  output logic [BITS-1:0]       m0_rsp_rdata,
  output logic                  m0_rsp_err,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [BITS-1:0]       m1_wdata,
  input  logic [3:0]            m1_wmask,
  output logic                  m1_rsp_valid,
  output logic [BITS-1:0]       m1_rsp_rdata,
  output logic                  m1_rsp_err,
  output logic                  r0_ce,
  output logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [BITS-1:0]       r0_rd,
  output logic                  rw0_ce,
  output logic                  rw0_we,
  output logic [ADDR_WIDTH-1:0] rw0_addr,
  output logic [BITS-1:0]       rw0_wd,
  output logic [3:0]            rw0_wmask,
  input  logic [BITS-1:0]       rw0_rd
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [31:0]           stat_wr_cnt,
  output logic [31:0]           stat_rd_cnt,
  output logic [31:0]           stat_stall_cnt,
  output logic [31:0]           stat_err_cnt
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = WORD_DEPTH[ADDR_WIDTH:0];

  // rw0 only ever writes, so its read data has no consumer.
  logic unused_rw0_rd;
  assign unused_rw0_rd = ^rw0_rd;

  logic [1:0]                 vld, we, oor, wc, rc, wg, rg_pre, rg, acc;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][BITS-1:0]       wdata;
  logic [1:0][3:0]            wmask;
  logic                       wsel, rsel, haz;
  logic                       rr_q, rr_d;
  logic [ADDR_WIDTH-1:0]      r_addr_q, w_addr_q;
  logic [BITS-1:0]            w_wd_q;
  logic [3:0]                 w_mask_q;
  logic [1:0]                 rsp_v_q, rsp_e_q, rsp_r_q;

  assign vld   = {m1_valid, m0_valid};
  assign we    = {m1_we, m0_we};
  assign addr  = {m1_addr, m0_addr};
  assign wdata = {m1_wdata, m0_wdata};
  assign wmask = {m1_wmask, m0_wmask};

  // Two contenders go to the round-robin owner; a lone contender always wins.
  function automatic logic [1:0] arb(input logic [1:0] c, input logic ptr);
    return (c == 2'b11) ? (ptr ? 2'b10 : 2'b01) : c;
  endfunction

  // Range check, write slot, read slot, then same-address read stall.
  always_comb begin
    for (int i = 0; i < 2; i++)
      oor[i] = vld[i] && !sys_rst && ({1'b0, addr[i]} >= DEPTH_L);
    wc     = vld & we  & ~oor & {2{!sys_rst}};
    rc     = vld & ~we & ~oor & {2{!sys_rst}};
    wg     = arb(wc, rr_q);
    rg_pre = arb(rc, rr_q);
    wsel   = wg[1];
    rsel   = rg_pre[1];
    haz    = (|wg) && (|rg_pre) && (addr[wsel] == addr[rsel]);
    rg     = haz ? 2'b00 : rg_pre;
    acc    = wg | rg | oor;
    rr_d   = ((&vld) && (^acc)) ? !rr_q : rr_q;
  end

  assign m0_ready = acc[0];
  assign m1_ready = acc[1];

  // Idle ports replay the last address/data so the macro pins do not toggle.
  assign rw0_ce    = |wg;
  assign rw0_we    = |wg;
  assign rw0_addr  = (|wg) ? addr[wsel]  : w_addr_q;
  assign rw0_wd    = (|wg) ? wdata[wsel] : w_wd_q;
  assign rw0_wmask = (|wg) ? wmask[wsel] : w_mask_q;
  assign r0_ce     = |rg;
  assign r0_addr   = (|rg) ? addr[rsel]  : r_addr_q;

  // Read data is routed only in the cycle after a read grant, by source tag.
  assign m0_rsp_valid = rsp_v_q[0];
  assign m1_rsp_valid = rsp_v_q[1];
  assign m0_rsp_err   = rsp_e_q[0];
  assign m1_rsp_err   = rsp_e_q[1];
  assign m0_rsp_rdata = rsp_r_q[0] ? r0_rd : '0;
  assign m1_rsp_rdata = rsp_r_q[1] ? r0_rd : '0;

  // Priority pointer, response tags and held port values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rr_q     <= 1'b0;
      rsp_v_q  <= '0;
      rsp_e_q  <= '0;
      rsp_r_q  <= '0;
      r_addr_q <= '0;
      w_addr_q <= '0;
      w_wd_q   <= '0;
      w_mask_q <= '0;
    end else begin
      rr_q    <= rr_d;
      rsp_v_q <= acc;
      rsp_e_q <= oor;
      rsp_r_q <= rg;
      if (|rg) r_addr_q <= r0_addr;
      if (|wg) begin
        w_addr_q <= rw0_addr;
        w_wd_q   <= rw0_wd;
        w_mask_q <= rw0_wmask;
      end
    end
  end

`ifdef SRAM_ARB_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] c, input logic [1:0] n);
    logic [32:0] s;
    s = {1'b0, c} + {31'd0, n};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  logic [1:0] n_wr, n_rd, n_err, n_stall;
  assign n_wr    = {1'b0, |wg};
  assign n_rd    = {1'b0, |rg};
  assign n_err   = {1'b0, oor[0]} + {1'b0, oor[1]};
  assign n_stall = {1'b0, (|(vld & ~acc)) && !sys_rst};

  // Saturating event counters.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      stat_wr_cnt    <= '0;
      stat_rd_cnt    <= '0;
      stat_stall_cnt <= '0;
      stat_err_cnt   <= '0;
    end else begin
      stat_wr_cnt    <= sat_add(stat_wr_cnt, n_wr);
      stat_rd_cnt    <= sat_add(stat_rd_cnt, n_rd);
      stat_stall_cnt <= sat_add(stat_stall_cnt, n_stall);
      stat_err_cnt   <= sat_add(stat_err_cnt, n_err);
    end
  end
`endif

endmodule
